router_out_arbiter: RTL

- Packet-granular round-robin arbiter merging the three per-destination router FIFOs onto one shared 8-bit output link.
- Sequences FIFO reads: selects a non-empty FIFO, streams one whole packet (header, payload, parity) under a valid/ready handshake, then re-arbitrates.
- Watchdog soft-resets a FIFO that stalls mid-packet.
- Sits between the three router FIFOs and the shared downstream port.

---
 rtl/router_out_arbiter_if.sv | 26 ++
 rtl/router_out_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter_if.sv
// FIFO-side and link-side handshake bundle for router_out_arbiter.
// master = arbiter view, slave = FIFO/downstream environment view.
interface router_out_arbiter_if #(
  parameter int unsigned DW = 8
);
  logic [2:0]    fifo_empty;
  logic [DW-1:0] fifo_dout_0;
  logic [DW-1:0] fifo_dout_1;
  logic [DW-1:0] fifo_dout_2;
  logic [2:0]    fifo_rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;

  modport master (
    input  fifo_empty, fifo_dout_0, fifo_dout_1, fifo_dout_2, out_ready,
    output fifo_rd_en, out_data, out_valid, out_sop, out_eop
  );

  modport slave (
    output fifo_empty, fifo_dout_0, fifo_dout_1, fifo_dout_2, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/router_out_arbiter.sv
// Packet-granular round-robin merge of three show-ahead FIFOs onto one link, with stall watchdog.
// Optional OUT_PARITY_CHECK_EN adds a parity_err output checking each packet's trailing parity byte.
module router_out_arbiter #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned DW      = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  router_out_arbiter_if.master       bus,
  output logic [2:0]                 grant,
  output logic                       busy,
  output logic [2:0]                 sft_rst
`ifdef OUT_PARITY_CHECK_EN
  ,
  output logic                       parity_err
`endif
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    sft_rst_q, sft_rst_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic [1:0]    gidx;
  logic [DW-1:0] head;
  logic          head_empty, active, hs, last, abort;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [2:0]    sum;

  always_comb begin
    gidx = 2'd0;
    unique case (grant_q)
      3'b010:  gidx = 2'd1;
      3'b100:  gidx = 2'd2;
      default: gidx = 2'd0;
    endcase
  end

  always_comb begin
    head = bus.fifo_dout_0;
    case (gidx)
      2'd1:    head = bus.fifo_dout_1;
      2'd2:    head = bus.fifo_dout_2;
      default: head = bus.fifo_dout_0;
    endcase
  end

  assign head_empty     = bus.fifo_empty[gidx];
  assign active         = (state_q != StIdle);
  assign bus.out_data   = head;
  assign bus.out_valid  = active & ~head_empty;
  assign hs             = bus.out_valid & bus.out_ready;
  assign bus.fifo_rd_en = hs ? grant_q : 3'b000;
  assign last           = (byte_cnt_q == 7'd1);
  assign bus.out_sop    = (state_q == StHdr) & bus.out_valid;
  assign bus.out_eop    = (state_q == StBody) & bus.out_valid & last;
  assign abort          = active & head_empty & (starve_cnt_q == CW'(TIMEOUT - 1));
  assign grant          = grant_q;
  assign busy           = active;
  assign sft_rst        = sft_rst_q;

  // Walk rr_ptr+3 down to rr_ptr+1 so the nearest non-empty FIFO overwrites the others.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    sum      = 3'd0;
    for (int k = 3; k >= 1; k--) begin
      sum = {1'b0, rr_ptr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!bus.fifo_empty[sum[1:0]]) begin
        pick     = sum[1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    starve_cnt_d = starve_cnt_q;
    sft_rst_d    = 3'b000;
    unique case (state_q)
      StIdle: begin
        starve_cnt_d = '0;
        if (pick_vld) begin
          grant_d = 3'b001 << pick;
          state_d = StHdr;
        end
      end
      StHdr, StBody: begin
        // Downstream stalls (valid & !ready) neither count nor clear.
        if (hs) starve_cnt_d = '0;
        else if (head_empty) starve_cnt_d = starve_cnt_q + CW'(1);
        if (abort) begin
          sft_rst_d    = grant_q;
          state_d      = StIdle;
          rr_ptr_d     = gidx;
          grant_d      = 3'b000;
          byte_cnt_d   = '0;
          starve_cnt_d = '0;
        end else if (hs) begin
          if (state_q == StHdr) begin
            byte_cnt_d = {1'b0, head[7:2]} + 7'd1;
            state_d    = StBody;
          end else begin
            byte_cnt_d = byte_cnt_q - 7'd1;
            if (last) begin
              state_d  = StIdle;
              rr_ptr_d = gidx;
              grant_d  = 3'b000;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      grant_q      <= 3'b000;
      sft_rst_q    <= 3'b000;
      rr_ptr_q     <= 2'd2;
      byte_cnt_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sft_rst_q    <= sft_rst_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef OUT_PARITY_CHECK_EN
  logic [DW-1:0] par_acc_q, par_acc_d;
  logic          parity_err_q, parity_err_d;

  always_comb begin
    par_acc_d    = par_acc_q;
    parity_err_d = 1'b0;
    if (state_q == StIdle) begin
      par_acc_d = '0;
    end else if (hs) begin
      if ((state_q == StBody) && last) parity_err_d = (par_acc_q != head);
      else par_acc_d = par_acc_q ^ head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      par_acc_q    <= '0;
      parity_err_q <= 1'b0;
    end else begin
      par_acc_q    <= par_acc_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif
endmodule
